ones_accumulator: RTL and testbench
===================================

# ones_accumulator

Parametrised, multi-cycle successor to the single-cycle ones counter. It accepts a wide feature vector through a valid/ready handshake and counts either set or cleared bits, processing CHUNK_WIDTH bits per cycle. It reports the count and a threshold-compare flag through a held valid/ready output. It sits between the feature register stage and the vote/compare logic, where wide vectors make a single-cycle popcount too slow.

## Interface
- INPUT_FEATURES, 32: width of the feature vector; must be ≥1.
- CHUNK_WIDTH, 8: bits counted per cycle. INPUT_FEATURES % CHUNK_WIDTH must be 0, otherwise elaboration fails.
- clock_i  input  1: single clock, rising edge.
- reset_i  input  1: synchronous, active-low reset.
- valid_i  input  1: input vector valid.
- ready_o  output  1: block can accept a vector.
- input_features_i  input  INPUT_FEATURES: vector to count.
- mode_i  input  1: 0 = count ones, 1 = count zeros.
- threshold_i  input  CW: compare threshold. CW = $clog2(INPUT_FEATURES+1).
- valid_o  output  1: result valid.
- ready_i  input  1: downstream accepts the result.
- ones_o  output  CW: count result.
- above_threshold_o  output  1: count ≥ captured threshold.

## Operation
- NUM_CHUNKS = INPUT_FEATURES / CHUNK_WIDTH.
- FSM has three states: IDLE, COUNT, DONE.
- IDLE
  - ready_o = 1 while reset_i is high.
  - On valid_i && ready_o, capture input_features_i, mode_i and threshold_i.
  - Clear the accumulator, set chunk index to 0, go to COUNT.
- COUNT
  - Each cycle, add the popcount of chunk[idx] (bits idx*CHUNK_WIDTH upward) to the accumulator. The chunk is bitwise-inverted first when the captured mode is 1.
  - Increment idx each cycle.
  - On the last chunk (idx = NUM_CHUNKS-1), register the final sum into ones_o and the compare into above_threshold_o, then go to DONE.
  - ready_o = 0.
- DONE
  - valid_o = 1; ones_o and above_threshold_o are held stable.
  - On ready_i, go to IDLE.
  - ready_o = 0; valid_i is ignored.
- Width rules
  - Chunk popcount is $clog2(CHUNK_WIDTH+1) bits, zero-extended to CW.
  - The accumulator is CW bits and cannot overflow, since the maximum sum is INPUT_FEATURES.
  - The compare is unsigned ≥. threshold 0 always yields 1.
- ones_o and above_threshold_o update only on entry to DONE. They keep the last result in IDLE and COUNT.
- Reset (reset_i low at a clock edge), including mid-COUNT or mid-DONE:
  - state → IDLE; valid_o = 0; ones_o = 0; above_threshold_o = 0; accumulator and idx = 0.
  - ready_o = 0 while reset_i is low, regardless of state.
  - An aborted count never produces valid_o.

## Timing
- Handshake at edge E0 (IDLE).
- COUNT accumulates chunk k at edge E(k+1).
- valid_o rises after edge E(NUM_CHUNKS). Latency is NUM_CHUNKS cycles from accept to valid_o.
- Output handshake at edge Ed: state becomes IDLE, ready_o = 1 in the following cycle.
- Minimum spacing between accepts is NUM_CHUNKS+2 cycles.
- With CHUNK_WIDTH = INPUT_FEATURES, latency is 1 cycle.
- ready_o and valid_o are decoded from registered state only. There is no combinational path from valid_i or ready_i.

## Structure
- Shared package ones_counter_pkg holds:
  - the state encoding (IDLE/COUNT/DONE);
  - a helper function for count width, $clog2(n+1).
- NUM_CHUNKS and CW are localparams in the block.
- One combinational sub-module, chunk_popcount (parameter WIDTH), counts the set bits of one chunk. It is reusable by other vote logic.
- Registers:
  - state;
  - idx, $clog2(NUM_CHUNKS) bits, minimum 1;
  - captured vector, mode and threshold;
  - accumulator;
  - ones_o and above_threshold_o.

## Test plan
All scenarios use INPUT_FEATURES=32, CHUNK_WIDTH=8 (NUM_CHUNKS=4).
- Reset: hold reset_i low 3 cycles with valid_i=1 → ready_o=0, valid_o=0, ones_o=0. After release, ready_o=1 and no result appears.
- Basic count: accept 0xF0F0_00FF, mode 0, threshold 16 → valid_o 4 cycles after the accept edge, ones_o=16, above_threshold_o=1.
- Zeros mode: same vector, mode 1, threshold 17 → ones_o=16, above_threshold_o=0.
- Extremes, one vector each:
  - 0xFFFF_FFFF, mode 0 → ones_o=32.
  - 0x0000_0000, mode 1 → ones_o=32.
  - 0x0000_0000, mode 0, threshold 0 → ones_o=0, above_threshold_o=1.
- Backpressure: hold ready_i low 5 cycles after valid_o while pulsing valid_i → valid_o, ones_o and above_threshold_o stay stable and ready_o=0. Raise ready_i → ready_o=1 next cycle. A new vector 0x0000_0001 then yields ones_o=1.
- Reset mid-count: pull reset_i low for one edge during the 2nd COUNT cycle → no valid_o, ones_o=0. A following accept of 0x8000_0001 yields ones_o=2 after 4 cycles.

Source files
------------

// File: rtl/ones_counter_pkg.sv
// Shared definitions for the ones-counting blocks: FSM state encoding and
// the count-width helper used to size popcount results.
package ones_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of one WIDTH-bit chunk; reusable by other
// vote logic.
module chunk_popcount
    import ones_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]              bits_i,
    output logic [count_width(WIDTH)-1:0] count_o
);

    localparam int unsigned PW = count_width(WIDTH);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count_o = count_o + PW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/ones_accumulator.sv
// Multi-cycle popcount of a wide feature vector, CHUNK_WIDTH bits per cycle,
// with ones/zeros mode and a registered threshold compare.
module ones_accumulator
    import ones_counter_pkg::*;
#(
    parameter int unsigned INPUT_FEATURES = 32,
    parameter int unsigned CHUNK_WIDTH    = 8
) (
    input  logic                                      clock_i,
    input  logic                                      reset_i,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    input  logic [INPUT_FEATURES-1:0]                 input_features_i,
    input  logic                                      mode_i,
    input  logic [count_width(INPUT_FEATURES)-1:0]    threshold_i,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic [count_width(INPUT_FEATURES)-1:0]    ones_o,
    output logic                                      above_threshold_o
);

    localparam int unsigned NUM_CHUNKS = INPUT_FEATURES / CHUNK_WIDTH;
    localparam int unsigned CW         = count_width(INPUT_FEATURES);
    localparam int unsigned PW         = count_width(CHUNK_WIDTH);
    localparam int unsigned IW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if (INPUT_FEATURES < 1 || CHUNK_WIDTH < 1 ||
        (INPUT_FEATURES % CHUNK_WIDTH) != 0) begin : g_bad_cfg
        $error("ones_accumulator: INPUT_FEATURES must be a nonzero multiple of CHUNK_WIDTH");
    end

    state_e                    state_q, state_d;
    logic [INPUT_FEATURES-1:0] vec_q;
    logic                      mode_q;
    logic [CW-1:0]             thr_q;
    logic [CW-1:0]             acc_q;
    logic [IW-1:0]             idx_q;
    logic [CW-1:0]             ones_q;
    logic                      above_q;

    logic                      accept;
    logic                      last_chunk;
    logic [CHUNK_WIDTH-1:0]    chunk;
    logic [PW-1:0]             chunk_cnt;
    logic [CW-1:0]             sum_d;

    assign accept     = valid_i && ready_o;
    assign last_chunk = (idx_q == IW'(NUM_CHUNKS - 1));

    // Zeros mode counts the set bits of the inverted chunk.
    always_comb begin
        chunk = vec_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk = chunk ^ {CHUNK_WIDTH{mode_q}};
    end

    chunk_popcount #(
        .WIDTH (CHUNK_WIDTH)
    ) u_chunk_popcount (
        .bits_i  (chunk),
        .count_o (chunk_cnt)
    );

    assign sum_d = acc_q + CW'(chunk_cnt);

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)     state_d = ST_COUNT;
            ST_COUNT: if (last_chunk) state_d = ST_DONE;
            ST_DONE:  if (ready_i)    state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o = reset_i && (state_q == ST_IDLE);
        valid_o = (state_q == ST_DONE);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            vec_q   <= '0;
            mode_q  <= 1'b0;
            thr_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            above_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        vec_q  <= input_features_i;
                        mode_q <= mode_i;
                        thr_q  <= threshold_i;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                ST_COUNT: begin
                    acc_q <= sum_d;
                    if (last_chunk) begin
                        idx_q   <= '0;
                        ones_q  <= sum_d;
                        above_q <= (sum_d >= thr_q);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ones_o            = ones_q;
    assign above_threshold_o = above_q;

endmodule

// File: tb/tb_ones_accumulator.sv
// Randomised self-checking bench for ones_accumulator (32 features, 8-bit chunks)
// against a bit-by-bit behavioural count.
module tb_ones_accumulator;

    localparam int unsigned NF = 32;
    localparam int unsigned CW = 6;
    localparam int unsigned LATENCY = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [NF-1:0] input_features_i = '0;
    logic          mode_i = 1'b0;
    logic [CW-1:0] threshold_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [CW-1:0] ones_o;
    logic          above_threshold_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned last_ones  = 0;
    logic        last_above = 1'b0;

    ones_accumulator #(
        .INPUT_FEATURES (NF),
        .CHUNK_WIDTH    (8)
    ) dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .input_features_i  (input_features_i),
        .mode_i            (mode_i),
        .threshold_i       (threshold_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .ones_o            (ones_o),
        .above_threshold_o (above_threshold_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_count(input logic [NF-1:0] v, input logic m);
        int unsigned c = 0;
        for (int i = 0; i < NF; i++) if (v[i] != m) c++;
        return c;
    endfunction

    // Full transaction: accept, check latency and held outputs, stall for
    // `hold` cycles with valid_i pulsing, then hand the result off.
    task automatic run_vec(input logic [NF-1:0] v, input logic m, input logic [CW-1:0] thr,
                           input int unsigned hold);
        int unsigned exp_ones;
        logic        exp_above;
        int unsigned lat;
        int unsigned w;
        exp_ones  = model_count(v, m);
        exp_above = (exp_ones >= thr);
        w = 0;
        while (!ready_o && w < 10) begin
            @(negedge clock_i);
            w++;
        end
        check_eq("ready_before_accept", 32'(ready_o), 32'd1);
        input_features_i = v;
        mode_i           = m;
        threshold_i      = thr;
        valid_i          = 1'b1;
        @(negedge clock_i);
        valid_i          = 1'b0;
        input_features_i = NF'($urandom);
        mode_i           = 1'($urandom);
        threshold_i      = CW'($urandom);
        lat = 0;
        while (!valid_o && lat < 20) begin
            check_eq("ready_low_in_count", 32'(ready_o), 32'd0);
            check_eq("ones_held_in_count", 32'(ones_o), 32'(last_ones));
            @(negedge clock_i);
            lat++;
        end
        check_eq("latency", lat, LATENCY);
        check_eq("ones", 32'(ones_o), exp_ones);
        check_eq("above", 32'(above_threshold_o), 32'(exp_above));
        for (int unsigned i = 0; i < hold; i++) begin
            valid_i = 1'($urandom);
            @(negedge clock_i);
            check_eq("hold_valid", 32'(valid_o), 32'd1);
            check_eq("hold_ready", 32'(ready_o), 32'd0);
            check_eq("hold_ones", 32'(ones_o), exp_ones);
            check_eq("hold_above", 32'(above_threshold_o), 32'(exp_above));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clock_i);
        ready_i = 1'b0;
        check_eq("post_handoff_ready", 32'(ready_o), 32'd1);
        check_eq("post_handoff_valid", 32'(valid_o), 32'd0);
        check_eq("ones_held_in_idle", 32'(ones_o), exp_ones);
        last_ones  = exp_ones;
        last_above = exp_above;
    endtask

    initial begin
        // Reset held 3 cycles with valid_i asserted.
        reset_i = 1'b0;
        valid_i = 1'b1;
        input_features_i = 32'hFFFF_FFFF;
        repeat (3) @(negedge clock_i);
        check_eq("rst_ready", 32'(ready_o), 32'd0);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_ones", 32'(ones_o), 32'd0);
        reset_i = 1'b1;
        valid_i = 1'b0;
        #1;
        check_eq("rel_ready", 32'(ready_o), 32'd1);
        repeat (6) begin
            @(negedge clock_i);
            check_eq("rel_no_result", 32'(valid_o), 32'd0);
        end

        // Directed vectors.
        run_vec(32'hF0F0_00FF, 1'b0, 6'd16, 0);
        run_vec(32'hF0F0_00FF, 1'b1, 6'd17, 0);
        run_vec(32'hFFFF_FFFF, 1'b0, 6'd32, 0);
        run_vec(32'h0000_0000, 1'b1, 6'd33, 0);
        run_vec(32'h0000_0000, 1'b0, 6'd0, 0);
        run_vec(32'h0000_0001, 1'b0, 6'd1, 5);
        run_vec(32'h0000_0001, 1'b0, 6'd2, 0);

        // Reset during the second COUNT cycle.
        input_features_i = 32'hFFFF_FFFF;
        mode_i      = 1'b0;
        threshold_i = 6'd1;
        valid_i     = 1'b1;
        @(negedge clock_i);
        valid_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b1;
        check_eq("abort_ones", 32'(ones_o), 32'd0);
        check_eq("abort_above", 32'(above_threshold_o), 32'd0);
        check_eq("abort_valid", 32'(valid_o), 32'd0);
        repeat (6) begin
            @(negedge clock_i);
            check_eq("abort_no_valid", 32'(valid_o), 32'd0);
        end
        last_ones  = 0;
        last_above = 1'b0;
        run_vec(32'h8000_0001, 1'b0, 6'd2, 0);

        // Randomised vectors, thresholds and downstream stalls.
        for (int n = 0; n < 40; n++) begin
            logic [NF-1:0] v;
            case ($urandom_range(0, 3))
                0: v = '0;
                1: v = '1;
                default: v = NF'($urandom);
            endcase
            run_vec(v, 1'($urandom), CW'($urandom_range(0, 40)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
